// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between the EX pipeline stage and alu_seq_exec.
// Latency: none (wires only).
// Backpressure: InValid/InReady on the request side, OutValid/OutReady on the result side.
//
// Port summary:
//   request  : InValid, InReady, ALUOp, FunctionCode, OperandA, OperandB, Shamt
//   response : OutValid, OutReady, Result, Hi, Zero
//   status   : Busy
// The master modport is the pipeline side; the slave modport is the execution unit.
interface alu_seq_exec_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               InValid;
    logic               InReady;
    logic [1:0]         ALUOp;
    logic [5:0]         FunctionCode;
    logic [WIDTH-1:0]   OperandA;
    logic [WIDTH-1:0]   OperandB;
    logic [SHAMT_W-1:0] Shamt;
    logic               OutValid;
    logic               OutReady;
    logic [WIDTH-1:0]   Result;
    logic [WIDTH-1:0]   Hi;
    logic               Zero;
    logic               Busy;

    modport master (
        output InValid, ALUOp, FunctionCode, OperandA, OperandB, Shamt, OutReady,
        input  InReady, OutValid, Result, Hi, Zero, Busy
    );

    modport slave (
        input  InValid, ALUOp, FunctionCode, OperandA, OperandB, Shamt, OutReady,
        output InReady, OutValid, Result, Hi, Zero, Busy
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Handshaked EX-stage ALU: decodes ALUOp/funct and executes add/sub/and/or/slt, iterative shifts and multu.
// Latency: 1 cycle for single-step ops, Shamt+1 for shifts, WIDTH+1 for multu.
// Backpressure: accepts only when idle; the result is held in DONE for as long as OutReady stays low.
//
// Ports: clk (rising edge), reset (synchronous, active high),
//        bus (alu_seq_exec_if.slave): request, response and Busy signals.
module alu_seq_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    alu_seq_exec_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
        OP_SLL, OP_SRL, OP_SRA, OP_MULTU
    } op_t;

    state_t state, state_nxt;

    op_t                op_in;
    op_t                op_q;
    logic               accept;
    logic               in_is_shift;
    logic [WIDTH-1:0]   imm_res;

    // Counter needs one extra bit so it can hold WIDTH for multu.
    logic [SHAMT_W:0]   cnt;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   sh_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     mul_sum;

    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   hi_q;
    logic               zero_q;

    // Opcode / funct decode; unknown R-type funct falls back to add.
    always_comb begin
        op_in = OP_ADD;
        case (bus.ALUOp)
            2'b00: op_in = OP_ADD;
            2'b01: op_in = OP_SUB;
            2'b11: op_in = OP_OR;
            default: begin
                case (bus.FunctionCode)
                    6'b000000: op_in = OP_SLL;
                    6'b000010: op_in = OP_SRL;
                    6'b000011: op_in = OP_SRA;
                    6'b100000: op_in = OP_ADD;
                    6'b100010: op_in = OP_SUB;
                    6'b100100: op_in = OP_AND;
                    6'b100101: op_in = OP_OR;
                    6'b101010: op_in = OP_SLT;
                    6'b011001: op_in = OP_MULTU;
                    default:   op_in = OP_ADD;
                endcase
            end
        endcase
    end

    assign in_is_shift = (op_in == OP_SLL) || (op_in == OP_SRL) || (op_in == OP_SRA);
    assign accept      = bus.InValid && (state == IDLE);

    // Single-step result; shifts land here only when Shamt is zero (pass B through).
    always_comb begin
        imm_res = '0;
        case (op_in)
            OP_SUB:  imm_res = bus.OperandA - bus.OperandB;
            OP_AND:  imm_res = bus.OperandA & bus.OperandB;
            OP_OR:   imm_res = bus.OperandA | bus.OperandB;
            OP_SLT:  imm_res = {{(WIDTH-1){1'b0}}, ($signed(bus.OperandA) < $signed(bus.OperandB))};
            OP_SLL, OP_SRL, OP_SRA: imm_res = bus.OperandB;
            default: imm_res = bus.OperandA + bus.OperandB;
        endcase
    end

    // One-bit shift step for the op captured on accept.
    always_comb begin
        sh_nxt = shreg;
        case (op_q)
            OP_SLL:  sh_nxt = {shreg[WIDTH-2:0], 1'b0};
            OP_SRL:  sh_nxt = {1'b0, shreg[WIDTH-1:1]};
            OP_SRA:  sh_nxt = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
            default: sh_nxt = shreg;
        endcase
    end

    // Shift-add step: the multiplier sits in the low half of prod and is consumed
    // from bit 0 while the partial sum (with its carry) enters from the top.
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
        prod_nxt = {mul_sum, prod[WIDTH-1:1]};
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt    = state;
        bus.InReady  = 1'b0;
        bus.OutValid = 1'b0;
        bus.Busy     = 1'b1;
        case (state)
            IDLE: begin
                bus.InReady = 1'b1;
                bus.Busy    = 1'b0;
                if (bus.InValid) begin
                    if (in_is_shift && (bus.Shamt != '0)) begin
                        state_nxt = SHIFT;
                    end else if (op_in == OP_MULTU) begin
                        state_nxt = MUL;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            SHIFT: begin
                if (cnt == (SHAMT_W+1)'(1)) state_nxt = DONE;
            end
            MUL: begin
                if (cnt == (SHAMT_W+1)'(1)) state_nxt = DONE;
            end
            DONE: begin
                bus.OutValid = 1'b1;
                if (bus.OutReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath. Result/Hi/Zero only change when entering DONE, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_ADD;
            cnt      <= '0;
            shreg    <= '0;
            mcand    <= '0;
            prod     <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op_in;
                        shreg <= bus.OperandB;
                        mcand <= bus.OperandA;
                        prod  <= {{WIDTH{1'b0}}, bus.OperandB};
                        if (op_in == OP_MULTU) begin
                            cnt <= (SHAMT_W+1)'(WIDTH);
                        end else begin
                            cnt <= {1'b0, bus.Shamt};
                        end
                        if (!(op_in == OP_MULTU) && !(in_is_shift && (bus.Shamt != '0))) begin
                            result_q <= imm_res;
                            hi_q     <= '0;
                            zero_q   <= (imm_res == '0);
                        end
                    end
                end
                SHIFT: begin
                    shreg <= sh_nxt;
                    cnt   <= cnt - 1'b1;
                    if (cnt == (SHAMT_W+1)'(1)) begin
                        result_q <= sh_nxt;
                        hi_q     <= '0;
                        zero_q   <= (sh_nxt == '0);
                    end
                end
                MUL: begin
                    prod <= prod_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == (SHAMT_W+1)'(1)) begin
                        result_q <= prod_nxt[WIDTH-1:0];
                        hi_q     <= prod_nxt[2*WIDTH-1:WIDTH];
                        zero_q   <= (prod_nxt[WIDTH-1:0] == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Result = result_q;
    assign bus.Hi     = hi_q;
    assign bus.Zero   = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: each feature task drives vectors and checks hand-computed values inline.
// Inputs are driven on the falling edge and outputs sampled on the falling edge.
// Latency is counted in rising edges from the accept edge to the first edge that sees OutValid.
module tb_alu_seq_exec;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   lat;

    alu_seq_exec_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait for OutValid; returns at a falling edge with lat set.
    task automatic run_op(input logic [1:0] aluop, input logic [5:0] funct,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        int n;
        n = 0;
        while (!bus.InReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.ALUOp        = aluop;
        bus.FunctionCode = funct;
        bus.OperandA     = a;
        bus.OperandB     = b;
        bus.Shamt        = sh;
        bus.InValid      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.InValid = 1'b0;
        lat = 1;
        while (!bus.OutValid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (bus.OutValid !== 1'b1) begin
            bad++;
            $display("FAIL timeout: OutValid=%b required 1 within 100 cycles", bus.OutValid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        total++; if (bus.InReady !== 1'b1)      begin bad++; $display("FAIL reset_inready: got %b want 1", bus.InReady); end
        total++; if (bus.OutValid !== 1'b0)     begin bad++; $display("FAIL reset_outvalid: got %b want 0", bus.OutValid); end
        total++; if (bus.Result !== 32'h0)      begin bad++; $display("FAIL reset_result: got %h want 0", bus.Result); end
        total++; if (bus.Hi !== 32'h0)          begin bad++; $display("FAIL reset_hi: got %h want 0", bus.Hi); end
        total++; if (bus.Zero !== 1'b1)         begin bad++; $display("FAIL reset_zero: got %b want 1", bus.Zero); end
        total++; if (bus.Busy !== 1'b0)         begin bad++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    endtask

    task automatic test_add_backpressure();
        run_op(2'b10, 6'b100000, 32'd5, 32'd7, 5'd0);
        total++; if (lat !== 1)                 begin bad++; $display("FAIL add_lat: got %0d want 1", lat); end
        total++; if (bus.Result !== 32'd12)     begin bad++; $display("FAIL add_result: got %h want 0000000c", bus.Result); end
        total++; if (bus.Zero !== 1'b0)         begin bad++; $display("FAIL add_zero: got %b want 0", bus.Zero); end
        total++; if (bus.Hi !== 32'h0)          begin bad++; $display("FAIL add_hi: got %h want 0", bus.Hi); end
        @(negedge clk);
        bus.OutReady = 1'b0;
        run_op(2'b10, 6'b100000, 32'd5, 32'd7, 5'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (bus.Result !== 32'd12)  begin bad++; $display("FAIL bp_hold_result[%0d]: got %h want 0000000c", i, bus.Result); end
            total++; if (bus.OutValid !== 1'b1)  begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus.OutValid); end
            total++; if (bus.InReady !== 1'b0)   begin bad++; $display("FAIL bp_inready[%0d]: got %b want 0", i, bus.InReady); end
        end
        bus.OutReady = 1'b1;
        @(negedge clk);
        total++; if (bus.OutValid !== 1'b0)     begin bad++; $display("FAIL bp_release_valid: got %b want 0", bus.OutValid); end
        total++; if (bus.InReady !== 1'b1)      begin bad++; $display("FAIL bp_release_inready: got %b want 1", bus.InReady); end
    endtask

    task automatic test_sub_zero();
        run_op(2'b01, 6'b000000, 32'h1234, 32'h1234, 5'd0);
        total++; if (bus.Result !== 32'h0)      begin bad++; $display("FAIL sub_result: got %h want 0", bus.Result); end
        total++; if (bus.Zero !== 1'b1)         begin bad++; $display("FAIL sub_zero: got %b want 1", bus.Zero); end
        @(negedge clk);
    endtask

    task automatic test_slt();
        run_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0);
        total++; if (bus.Result !== 32'd1)      begin bad++; $display("FAIL slt_neg: got %h want 00000001", bus.Result); end
        @(negedge clk);
        run_op(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 5'd0);
        total++; if (bus.Result !== 32'd0)      begin bad++; $display("FAIL slt_swap: got %h want 0", bus.Result); end
        @(negedge clk);
    endtask

    task automatic test_logic();
        run_op(2'b11, 6'b000000, 32'h0000_00F0, 32'h0000_000F, 5'd0);
        total++; if (bus.Result !== 32'h0000_00FF) begin bad++; $display("FAIL or_aluop: got %h want 000000ff", bus.Result); end
        @(negedge clk);
        run_op(2'b10, 6'b100100, 32'h0000_FF00, 32'h0000_0FF0, 5'd0);
        total++; if (bus.Result !== 32'h0000_0F00) begin bad++; $display("FAIL and_funct: got %h want 00000f00", bus.Result); end
        @(negedge clk);
        run_op(2'b00, 6'b111111, 32'hFFFF_FFFF, 32'd2, 5'd0);
        total++; if (bus.Result !== 32'd1)      begin bad++; $display("FAIL add_wrap: got %h want 00000001", bus.Result); end
        @(negedge clk);
    endtask

    task automatic test_shift();
        run_op(2'b10, 6'b000011, 32'h8000_0000, 32'h8000_0000, 5'd4);
        total++; if (lat !== 5)                 begin bad++; $display("FAIL sra_lat: got %0d want 5", lat); end
        total++; if (bus.Result !== 32'hF800_0000) begin bad++; $display("FAIL sra_result: got %h want f8000000", bus.Result); end
        @(negedge clk);
        run_op(2'b10, 6'b000011, 32'h0, 32'h8000_0000, 5'd0);
        total++; if (lat !== 1)                 begin bad++; $display("FAIL shamt0_lat: got %0d want 1", lat); end
        total++; if (bus.Result !== 32'h8000_0000) begin bad++; $display("FAIL shamt0_result: got %h want 80000000", bus.Result); end
        @(negedge clk);
        run_op(2'b10, 6'b000010, 32'h0, 32'h8000_0000, 5'd31);
        total++; if (lat !== 32)                begin bad++; $display("FAIL srl31_lat: got %0d want 32", lat); end
        total++; if (bus.Result !== 32'd1)      begin bad++; $display("FAIL srl31_result: got %h want 00000001", bus.Result); end
        @(negedge clk);
        run_op(2'b10, 6'b000000, 32'h0, 32'h0000_00F1, 5'd4);
        total++; if (lat !== 5)                 begin bad++; $display("FAIL sll_lat: got %0d want 5", lat); end
        total++; if (bus.Result !== 32'h0000_0F10) begin bad++; $display("FAIL sll_result: got %h want 00000f10", bus.Result); end
        @(negedge clk);
    endtask

    task automatic test_multu();
        run_op(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        total++; if (lat !== 33)                begin bad++; $display("FAIL mul_lat: got %0d want 33", lat); end
        total++; if (bus.Hi !== 32'hFFFF_FFFE)  begin bad++; $display("FAIL mul_hi: got %h want fffffffe", bus.Hi); end
        total++; if (bus.Result !== 32'd1)      begin bad++; $display("FAIL mul_lo: got %h want 00000001", bus.Result); end
        @(negedge clk);
        run_op(2'b10, 6'b011001, 32'd3, 32'd4, 5'd0);
        total++; if (bus.Hi !== 32'h0)          begin bad++; $display("FAIL mul34_hi: got %h want 0", bus.Hi); end
        total++; if (bus.Result !== 32'd12)     begin bad++; $display("FAIL mul34_lo: got %h want 0000000c", bus.Result); end
        @(negedge clk);
        // A following add must clear Hi.
        run_op(2'b00, 6'b000000, 32'd1, 32'd1, 5'd0);
        total++; if (bus.Hi !== 32'h0)          begin bad++; $display("FAIL hi_cleared: got %h want 0", bus.Hi); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.ALUOp        = 2'b10;
        bus.FunctionCode = 6'b011001;
        bus.OperandA     = 32'd9;
        bus.OperandB     = 32'd9;
        bus.InValid      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.InValid = 1'b0;
        repeat (9) @(negedge clk);
        total++; if (bus.Busy !== 1'b1)         begin bad++; $display("FAIL mid_busy: got %b want 1", bus.Busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (bus.InReady !== 1'b1)      begin bad++; $display("FAIL mid_inready: got %b want 1", bus.InReady); end
        total++; if (bus.OutValid !== 1'b0)     begin bad++; $display("FAIL mid_outvalid: got %b want 0", bus.OutValid); end
        total++; if (bus.Result !== 32'h0)      begin bad++; $display("FAIL mid_result: got %h want 0", bus.Result); end
        total++; if (bus.Busy !== 1'b0)         begin bad++; $display("FAIL mid_busy_clr: got %b want 0", bus.Busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.OutValid === 1'b1) seen++;
        end
        total++; if (seen !== 0)                begin bad++; $display("FAIL mid_stale: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_unknown_funct();
        run_op(2'b10, 6'b111111, 32'd2, 32'd3, 5'd0);
        total++; if (bus.Result !== 32'd5)      begin bad++; $display("FAIL unknown_funct: got %h want 00000005", bus.Result); end
        @(negedge clk);
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        lat              = 0;
        reset            = 1'b1;
        bus.InValid      = 1'b0;
        bus.ALUOp        = 2'b00;
        bus.FunctionCode = 6'b000000;
        bus.OperandA     = 32'h0;
        bus.OperandB     = 32'h0;
        bus.Shamt        = 5'd0;
        bus.OutReady     = 1'b1;
        @(negedge clk);
        test_reset();
        test_add_backpressure();
        test_sub_zero();
        test_slt();
        test_logic();
        test_shift();
        test_multu();
        test_reset_mid();
        test_unknown_funct();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
